// File: rtl/smvm_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : smvm_issue_scheduler
// Purpose  : Packs the sparse-matrix nonzero stream (value, column, row-end)
//            into K-lane issue groups for the ALU/IPV-reducer pipeline.
//            Throttles issue against a credit count of groups in flight,
//            zero-pads the final partial group, and pulses done once every
//            issued group has returned a result.
// Ports    : clk, rst (async, active-high)
//            start                 - 1-cycle pulse, honoured only in IDLE
//            in_valid/in_ready     - nonzero stream handshake
//            in_val/in_col/in_ipv  - value, column index, row-end bit
//            in_last               - last nonzero of the matrix
//            issue_valid           - 1-cycle group issue strobe
//            issue_mat/col/ipv     - packed lanes, lane0 in the MSBs
//            res_valid             - one group result returned (frees a credit)
//            busy/done             - activity flag, 1-cycle completion pulse
//            row_count             - rows issued since start
//            err_underflow         - sticky: result seen with nothing in flight
// Revision : 1.0 - initial release
// ============================================================================
module smvm_issue_scheduler #(
    parameter int K            = 4,
    parameter int K_BIT        = 3,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_BIT      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_val,
    input  logic [8:0]         in_col,
    input  logic               in_ipv,
    input  logic               in_last,
    output logic               issue_valid,
    output logic [8*K-1:0]     issue_mat,
    output logic [9*K-1:0]     issue_col,
    output logic [K-1:0]       issue_ipv,
    input  logic               res_valid,
    output logic               busy,
    output logic               done,
    output logic [CNT_BIT-1:0] row_count,
    output logic               err_underflow
);

    localparam int                 c_IF_W      = $clog2(MAX_INFLIGHT + 1);
    localparam logic [c_IF_W-1:0]  c_MAX_IF    = c_IF_W'(MAX_INFLIGHT);
    localparam logic [K_BIT-1:0]   c_LAST_LANE = K_BIT'(K - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FILL  = 3'd1;
    localparam logic [2:0] c_ST_ISSUE = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [K_BIT-1:0]   r_lane_cnt;
    logic [7:0]         r_mat [K];
    logic [8:0]         r_col [K];
    logic [K-1:0]       r_ipv;        // bit i belongs to lane i
    logic               r_final;      // current group holds the in_last entry
    logic [c_IF_W-1:0]  r_inflight;
    logic [CNT_BIT-1:0] r_row_count;
    logic               r_err;

    logic               w_accept;
    logic               w_close;
    logic               w_issue;
    logic               w_res_ok;
    logic [CNT_BIT-1:0] w_pop;

    assign w_accept = in_valid && (r_state == c_ST_FILL);
    // The group closes on the K-th entry or on the matrix's last entry.
    assign w_close  = w_accept && ((r_lane_cnt == c_LAST_LANE) || in_last);
    assign w_issue  = (r_state == c_ST_ISSUE) && (r_inflight < c_MAX_IF);
    // A result with nothing in flight is flagged but never decrements.
    assign w_res_ok = res_valid && (r_inflight != '0);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < K; i++) begin
            w_pop = w_pop + CNT_BIT'(r_ipv[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_lane_cnt  <= '0;
            r_ipv       <= '0;
            r_final     <= 1'b0;
            r_inflight  <= '0;
            r_row_count <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < K; i++) begin
                r_mat[i] <= '0;
                r_col[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state     <= c_ST_FILL;
                        r_row_count <= '0;
                        r_lane_cnt  <= '0;
                        r_final     <= 1'b0;
                    end
                end
                c_ST_FILL: begin
                    if (w_accept) begin
                        for (int i = 0; i < K; i++) begin
                            if (K_BIT'(i) == r_lane_cnt) begin
                                r_mat[i] <= in_val;
                                r_col[i] <= in_col;
                                // The matrix's last entry always ends a row.
                                r_ipv[i] <= in_ipv | in_last;
                            end
                        end
                        r_lane_cnt <= r_lane_cnt + K_BIT'(1);
                        if (in_last) begin
                            r_final <= 1'b1;
                        end
                        if (w_close) begin
                            r_state <= c_ST_ISSUE;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    if (w_issue) begin
                        r_row_count <= r_row_count + w_pop;
                        r_lane_cnt  <= '0;
                        // Clearing the buffers leaves unused lanes of a later
                        // partial group at zero.
                        r_ipv       <= '0;
                        for (int i = 0; i < K; i++) begin
                            r_mat[i] <= '0;
                            r_col[i] <= '0;
                        end
                        r_final <= 1'b0;
                        r_state <= r_final ? c_ST_DRAIN : c_ST_FILL;
                    end
                end
                c_ST_DRAIN: begin
                    if (r_inflight == '0) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            case ({w_issue, w_res_ok})
                2'b10:   r_inflight <= r_inflight + c_IF_W'(1);
                2'b01:   r_inflight <= r_inflight - c_IF_W'(1);
                default: r_inflight <= r_inflight;
            endcase

            if (res_valid && (r_inflight == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Lane buffers are presented only during the issue strobe.
    always_comb begin
        issue_mat = '0;
        issue_col = '0;
        issue_ipv = '0;
        if (w_issue) begin
            for (int i = 0; i < K; i++) begin
                issue_mat[8*(K-1-i) +: 8] = r_mat[i];
                issue_col[9*(K-1-i) +: 9] = r_col[i];
                issue_ipv[K-1-i]          = r_ipv[i];
            end
        end
    end

    assign issue_valid   = w_issue;
    assign in_ready      = (r_state == c_ST_FILL);
    assign busy          = (r_state != c_ST_IDLE);
    assign done          = (r_state == c_ST_DONE);
    assign row_count     = r_row_count;
    assign err_underflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_smvm_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_smvm_issue_scheduler
// Purpose  : Directed self-checking bench for smvm_issue_scheduler with
//            hand-computed expected issue groups, credit stalls, drain/done
//            timing, underflow flag and asynchronous reset abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smvm_issue_scheduler;

    localparam int K       = 4;
    localparam int CNT_BIT = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_val;
    logic [8:0]         in_col;
    logic               in_ipv;
    logic               in_last;
    logic               issue_valid;
    logic [8*K-1:0]     issue_mat;
    logic [9*K-1:0]     issue_col;
    logic [K-1:0]       issue_ipv;
    logic               res_valid;
    logic               busy;
    logic               done;
    logic [CNT_BIT-1:0] row_count;
    logic               err_underflow;

    logic [72:0]        w_issue_vec;
    assign w_issue_vec = {issue_valid, issue_mat, issue_col, issue_ipv};

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    smvm_issue_scheduler #(
        .K            (4),
        .K_BIT        (3),
        .MAX_INFLIGHT (4),
        .CNT_BIT      (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_val        (in_val),
        .in_col        (in_col),
        .in_ipv        (in_ipv),
        .in_last       (in_last),
        .issue_valid   (issue_valid),
        .issue_mat     (issue_mat),
        .issue_col     (issue_col),
        .issue_ipv     (issue_ipv),
        .res_valid     (res_valid),
        .busy          (busy),
        .done          (done),
        .row_count     (row_count),
        .err_underflow (err_underflow)
    );

    // Called at a falling edge; returns at the next falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one entry, waits (bounded) for in_ready, returns at the
    // falling edge right after the accepting rising edge.
    task automatic push(input logic [7:0] v, input logic [8:0] c,
                        input logic ipv, input logic last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_val   = v;
        in_col   = c;
        in_ipv   = ipv;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL push_ready: in_ready=%b after %0d cycles, expected 1", in_ready, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_ipv   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_res(input int cycles);
        res_valid = 1'b1;
        repeat (cycles) @(negedge clk);
        res_valid = 1'b0;
    endtask

    // Returns cycles waited for done, or -1 if the bound expired.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_val = '0; in_col = '0;
        in_ipv = 1'b0; in_last = 1'b0; res_valid = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if ({busy, in_ready, done, err_underflow, row_count, w_issue_vec} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: busy=%b rdy=%b done=%b err=%b rows=%0d issue=%h, expected all 0",
                     busy, in_ready, done, err_underflow, row_count, w_issue_vec);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({busy, in_ready, issue_valid} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_idle: busy/rdy/iv=%b, expected 000", {busy, in_ready, issue_valid});
        end
    endtask

    task automatic test_full_groups();
        int n;
        pulse_start();
        compared++;
        if ({busy, in_ready, row_count} !== {2'b11, 16'd0}) begin
            mismatched++;
            $display("FAIL fill_entry: busy=%b rdy=%b rows=%0d, expected 1 1 0", busy, in_ready, row_count);
        end
        push(8'h11, 9'd1, 1'b0, 1'b0);
        push(8'h12, 9'd2, 1'b0, 1'b0);
        push(8'h13, 9'd3, 1'b0, 1'b0);
        push(8'h14, 9'd4, 1'b1, 1'b0);
        compared++;
        if (w_issue_vec !== {1'b1, 32'h11121314, 9'd1, 9'd2, 9'd3, 9'd4, 4'b0001}) begin
            mismatched++;
            $display("FAIL full_group1: got %h, expected %h", w_issue_vec,
                     {1'b1, 32'h11121314, 9'd1, 9'd2, 9'd3, 9'd4, 4'b0001});
        end
        @(negedge clk);
        compared++;
        if ({issue_valid, in_ready, row_count} !== {2'b01, 16'd1}) begin
            mismatched++;
            $display("FAIL after_group1: iv=%b rdy=%b rows=%0d, expected 0 1 1", issue_valid, in_ready, row_count);
        end
        push(8'h15, 9'd5, 1'b0, 1'b0);
        push(8'h16, 9'd6, 1'b1, 1'b0);
        push(8'h17, 9'd7, 1'b0, 1'b0);
        push(8'h18, 9'd8, 1'b1, 1'b1);
        compared++;
        if (w_issue_vec !== {1'b1, 32'h15161718, 9'd5, 9'd6, 9'd7, 9'd8, 4'b0101}) begin
            mismatched++;
            $display("FAIL full_group2: got %h, expected %h", w_issue_vec,
                     {1'b1, 32'h15161718, 9'd5, 9'd6, 9'd7, 9'd8, 4'b0101});
        end
        @(negedge clk);
        compared++;
        if ({row_count, done, busy, in_ready} !== {16'd3, 3'b010}) begin
            mismatched++;
            $display("FAIL drain_entry: rows=%0d done=%b busy=%b rdy=%b, expected 3 0 1 0",
                     row_count, done, busy, in_ready);
        end
        pulse_res(2);
        wait_done(n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL done_full: done=%b never seen, expected 1", done);
        end
        @(negedge clk);
        compared++;
        if ({done, busy} !== 2'b00) begin
            mismatched++;
            $display("FAIL done_pulse: done/busy=%b, expected 00", {done, busy});
        end
    endtask

    task automatic test_partial_group();
        int n;
        pulse_start();
        push(8'h21, 9'd101, 1'b0, 1'b0);
        push(8'h22, 9'd102, 1'b1, 1'b0);
        push(8'h23, 9'd103, 1'b0, 1'b0);
        push(8'h24, 9'd104, 1'b0, 1'b0);
        compared++;
        if (w_issue_vec !== {1'b1, 32'h21222324, 9'd101, 9'd102, 9'd103, 9'd104, 4'b0100}) begin
            mismatched++;
            $display("FAIL partial_group1: got %h, expected %h", w_issue_vec,
                     {1'b1, 32'h21222324, 9'd101, 9'd102, 9'd103, 9'd104, 4'b0100});
        end
        push(8'h25, 9'd105, 1'b0, 1'b0);
        push(8'h26, 9'd106, 1'b0, 1'b1);
        compared++;
        if (w_issue_vec !== {1'b1, 32'h25260000, 9'd105, 9'd106, 9'd0, 9'd0, 4'b0100}) begin
            mismatched++;
            $display("FAIL partial_pad: got %h, expected %h", w_issue_vec,
                     {1'b1, 32'h25260000, 9'd105, 9'd106, 9'd0, 9'd0, 4'b0100});
        end
        @(negedge clk);
        compared++;
        if (row_count !== 16'd2) begin
            mismatched++;
            $display("FAIL partial_rows: rows=%0d, expected 2", row_count);
        end
        pulse_res(2);
        wait_done(n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL done_partial: done never seen, expected 1");
        end
        @(negedge clk);
    endtask

    task automatic test_credit_stall();
        int n;
        pulse_start();
        for (int g = 0; g < 5; g++) begin
            for (int l = 0; l < 4; l++) begin
                n = 4 * g + l;
                push(8'(64 + n), 9'(200 + n), 1'b0, (n == 19));
            end
            if (g == 0) begin
                compared++;
                if (w_issue_vec !== {1'b1, 32'h40414243, 9'd200, 9'd201, 9'd202, 9'd203, 4'b0000}) begin
                    mismatched++;
                    $display("FAIL stall_group1: got %h, expected %h", w_issue_vec,
                             {1'b1, 32'h40414243, 9'd200, 9'd201, 9'd202, 9'd203, 4'b0000});
                end
            end else if (g < 4) begin
                compared++;
                if (issue_valid !== 1'b1) begin
                    mismatched++;
                    $display("FAIL stall_issue%0d: issue_valid=%b, expected 1", g, issue_valid);
                end
            end
        end
        compared++;
        if ({w_issue_vec, in_ready, busy} !== {73'd0, 2'b01}) begin
            mismatched++;
            $display("FAIL stall_hold: issue=%h rdy=%b busy=%b, expected 0 0 1", w_issue_vec, in_ready, busy);
        end
        repeat (2) @(negedge clk);
        compared++;
        if ({issue_valid, in_ready} !== 2'b00) begin
            mismatched++;
            $display("FAIL stall_hold2: iv/rdy=%b, expected 00", {issue_valid, in_ready});
        end
        pulse_res(1);
        compared++;
        if (w_issue_vec !== {1'b1, 32'h50515253, 9'd216, 9'd217, 9'd218, 9'd219, 4'b0001}) begin
            mismatched++;
            $display("FAIL stall_release: got %h, expected %h", w_issue_vec,
                     {1'b1, 32'h50515253, 9'd216, 9'd217, 9'd218, 9'd219, 4'b0001});
        end
        @(negedge clk);
        compared++;
        if (row_count !== 16'd1) begin
            mismatched++;
            $display("FAIL stall_rows: rows=%0d, expected 1", row_count);
        end
        pulse_res(4);
        wait_done(n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL done_stall: done never seen, expected 1");
        end
        @(negedge clk);
    endtask

    task automatic test_issue_with_result();
        int  n;
        bit  seen;
        pulse_start();
        for (int g = 0; g < 6; g++) begin
            for (int l = 0; l < 4; l++) begin
                n = 4 * g + l;
                push(8'(96 + n), 9'(300 + n), (l == 3), (n == 23));
            end
            compared++;
            if (issue_valid !== (g < 5)) begin
                mismatched++;
                $display("FAIL same_cycle_g%0d: issue_valid=%b, expected %b", g, issue_valid, (g < 5));
            end
            // Result returns on the same cycle the fourth group issues.
            if (g == 3) pulse_res(1);
        end
        pulse_res(1);
        compared++;
        if (issue_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL same_cycle_release: issue_valid=%b, expected 1", issue_valid);
        end
        @(negedge clk);
        compared++;
        if (row_count !== 16'd6) begin
            mismatched++;
            $display("FAIL same_cycle_rows: rows=%0d, expected 6", row_count);
        end
        pulse_res(3);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        compared++;
        if ({seen, busy} !== 2'b01) begin
            mismatched++;
            $display("FAIL early_done: done_seen=%b busy=%b, expected 0 1", seen, busy);
        end
        pulse_res(1);
        wait_done(n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL done_same_cycle: done never seen, expected 1");
        end
        @(negedge clk);
    endtask

    task automatic test_underflow_and_start();
        int n;
        compared++;
        if (err_underflow !== 1'b0) begin
            mismatched++;
            $display("FAIL err_clear: err=%b, expected 0", err_underflow);
        end
        pulse_res(1);
        compared++;
        if (err_underflow !== 1'b1) begin
            mismatched++;
            $display("FAIL err_set: err=%b, expected 1", err_underflow);
        end
        repeat (2) @(negedge clk);
        pulse_start();
        push(8'h81, 9'h1F0, 1'b1, 1'b0);
        push(8'h82, 9'h1F1, 1'b0, 1'b0);
        pulse_start();
        compared++;
        if ({in_ready, busy} !== 2'b11) begin
            mismatched++;
            $display("FAIL start_in_fill: rdy/busy=%b, expected 11", {in_ready, busy});
        end
        push(8'h83, 9'h1F2, 1'b1, 1'b0);
        push(8'h84, 9'h1F3, 1'b0, 1'b1);
        compared++;
        if (w_issue_vec !== {1'b1, 32'h81828384, 9'h1F0, 9'h1F1, 9'h1F2, 9'h1F3, 4'b1011}) begin
            mismatched++;
            $display("FAIL start_ignored_group: got %h, expected %h", w_issue_vec,
                     {1'b1, 32'h81828384, 9'h1F0, 9'h1F1, 9'h1F2, 9'h1F3, 4'b1011});
        end
        @(negedge clk);
        compared++;
        if ({row_count, err_underflow} !== {16'd3, 1'b1}) begin
            mismatched++;
            $display("FAIL err_sticky: rows=%0d err=%b, expected 3 1", row_count, err_underflow);
        end
        pulse_res(1);
        wait_done(n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL done_underflow: done never seen, expected 1");
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        int n;
        pulse_start();
        push(8'hA1, 9'h0A1, 1'b1, 1'b0);
        push(8'hA2, 9'h0A2, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({busy, in_ready, done, err_underflow, row_count, w_issue_vec} !== '0) begin
            mismatched++;
            $display("FAIL async_reset: busy=%b rdy=%b done=%b err=%b rows=%0d issue=%h, expected all 0",
                     busy, in_ready, done, err_underflow, row_count, w_issue_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        push(8'hB1, 9'h0AB, 1'b0, 1'b1);
        compared++;
        if (w_issue_vec !== {1'b1, 32'hB1000000, 9'h0AB, 9'd0, 9'd0, 9'd0, 4'b1000}) begin
            mismatched++;
            $display("FAIL clean_after_reset: got %h, expected %h", w_issue_vec,
                     {1'b1, 32'hB1000000, 9'h0AB, 9'd0, 9'd0, 9'd0, 4'b1000});
        end
        @(negedge clk);
        compared++;
        if (row_count !== 16'd1) begin
            mismatched++;
            $display("FAIL reset_rows: rows=%0d, expected 1", row_count);
        end
        pulse_res(1);
        wait_done(n);
        compared++;
        if (n < 0) begin
            mismatched++;
            $display("FAIL done_after_reset: done never seen, expected 1");
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_groups();
        test_partial_group();
        test_credit_stall();
        test_issue_with_result();
        test_underflow_and_start();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
